// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, PC step, NOP word and
// decoder bit-slice positions.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        StWait,
        StDrop,
        StBuf
    } fetch_state_e;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned FN_MSB = 5;
    localparam int unsigned FN_LSB = 0;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears valid, hold freezes everything, otherwise the
// register either loads a new instruction or takes a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    // Instruction and PC survive a flush or bubble; only valid drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!hold) begin
            valid <= load;
            if (load) begin
                instr <= d_instr;
                pc    <= d_pc;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem request bus, absorbs stalls in a
// one-entry skid buffer and applies branch/jump redirects ahead of the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic                 if_valid,
    output logic [31:0]          if_instr,
    output logic [31:0]          if_pc,
    output logic [31:0]          if_pc4,
    output logic [5:0]           op,
    output logic [5:0]           fn
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  drop_addr_q;
    logic [31:0]  skid_instr_q;
    logic [31:0]  skid_pc_q;
    logic [31:0]  target;
    logic         load;
    logic [31:0]  load_instr;
    logic [31:0]  load_pc;

    assign target        = word_align(redirect_pc);
    assign imem.imem_req  = (state_q != StBuf);
    assign imem.imem_addr = (state_q == StDrop) ? drop_addr_q : pc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StWait;
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
        end else begin
            unique case (state_q)
                StWait: begin
                    if (redirect_valid) begin
                        pc_q <= target;
                        // Keep the address stable for the in-flight request we now ignore.
                        if (!imem.imem_ack) begin
                            drop_addr_q <= pc_q;
                            state_q     <= StDrop;
                        end
                    end else if (imem.imem_ack) begin
                        pc_q <= pc_q + PC_INC;
                        if (stall) begin
                            skid_instr_q <= imem.imem_rdata;
                            skid_pc_q    <= pc_q;
                            state_q      <= StBuf;
                        end
                    end
                end
                StBuf: begin
                    if (redirect_valid) begin
                        pc_q    <= target;
                        state_q <= StWait;
                    end else if (!stall) begin
                        state_q <= StWait;
                    end
                end
                StDrop: begin
                    if (redirect_valid) pc_q <= target;
                    if (imem.imem_ack) state_q <= StWait;
                end
                default: state_q <= StWait;
            endcase
        end
    end

    always_comb begin
        load       = 1'b0;
        load_instr = imem.imem_rdata;
        load_pc    = pc_q;
        unique case (state_q)
            StWait: load = imem.imem_ack && !redirect_valid;
            StBuf: begin
                load       = !redirect_valid;
                load_instr = skid_instr_q;
                load_pc    = skid_pc_q;
            end
            default: load = 1'b0;
        endcase
    end

    if_id_reg u_if_id_reg (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .hold    (stall),
        .flush   (redirect_valid),
        .d_instr (load_instr),
        .d_pc    (load_pc),
        .valid   (if_valid),
        .instr   (if_instr),
        .pc      (if_pc)
    );

    assign if_pc4 = if_pc + PC_INC;
    // Zeroed slices make the decoder emit a NOP for a bubble.
    assign op = if_valid ? if_instr[OP_MSB:OP_LSB] : '0;
    assign fn = if_valid ? if_instr[FN_MSB:FN_LSB] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a program-order model predicts the bus and the IF/ID stream.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_ack;

    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc4;
    logic [5:0]  op, fn;

    logic        w_valid;
    logic [31:0] w_instr, w_pc, w_pc4;
    logic [5:0]  w_op, w_fn;

    int unsigned n_pass, n_total;

    // Model of the architectural fetch stream.
    logic [31:0] next_pc, stale_addr, exp_pc;
    logic        stale, skid_full, exp_valid, mon_en;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    fetch_stage_if bus ();
    fetch_stage_if bus_w ();

    assign bus.imem_ack     = mem_ack;
    assign bus.imem_rdata   = mem_word(bus.imem_addr);
    assign bus_w.imem_ack   = bus_w.imem_req;
    assign bus_w.imem_rdata = mem_word(bus_w.imem_addr);

    fetch_stage u_dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus.master),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .op             (op),
        .fn             (fn)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clock          (clock),
        .reset          (reset),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem           (bus_w.master),
        .if_valid       (w_valid),
        .if_instr       (w_instr),
        .if_pc          (w_pc),
        .if_pc4         (w_pc4),
        .op             (w_op),
        .fn             (w_fn)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Called at a negedge: check the bus, advance the model, drive inputs for the next edge.
    task automatic drive_cycle(input logic stl, input logic rdr, input logic ack_want,
                               input logic [31:0] tgt);
        logic exp_req, ack;
        exp_req = !skid_full;
        check("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", bus.imem_addr, stale ? stale_addr : next_pc);
        ack = ack_want && exp_req;
        if (rdr) begin
            if (exp_req && !ack) begin
                if (!stale) stale_addr = next_pc;
                stale = 1'b1;
            end else begin
                stale = 1'b0;
            end
            next_pc   = tgt & ~32'h3;
            skid_full = 1'b0;
            exp_q.delete();
        end else if (exp_req && ack) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                exp_q.push_back(next_pc);
                next_pc = next_pc + 32'd4;
                if (stl) skid_full = 1'b1;
            end
        end else if (skid_full && !stl) begin
            skid_full = 1'b0;
        end
        stall          = stl;
        redirect_valid = rdr;
        redirect_pc    = tgt;
        mem_ack        = ack;
    endtask

    // Monitor: after every edge, derive what IF/ID must show and compare.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (mon_en) begin
                if (redirect_valid) begin
                    exp_valid = 1'b0;
                end else if (!stall) begin
                    if (exp_q.size() > 0) begin
                        exp_pc    = exp_q.pop_front();
                        exp_valid = 1'b1;
                    end else begin
                        exp_valid = 1'b0;
                    end
                end
                check("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
                if (exp_valid) begin
                    check("if_pc", if_pc, exp_pc);
                    check("if_instr", if_instr, mem_word(exp_pc));
                    check("if_pc4", if_pc4, exp_pc + 32'd4);
                    check("op", {26'b0, op}, {26'b0, mem_word(exp_pc) >> 26});
                    check("fn", {26'b0, fn}, {26'b0, mem_word(exp_pc) & 32'h3F});
                end else begin
                    check("op_nop", {26'b0, op}, 32'h0);
                    check("fn_nop", {26'b0, fn}, 32'h0);
                end
            end
        end
    end

    initial begin
        logic stl, rdr, ack;
        logic [31:0] tgt;
        n_pass = 0; n_total = 0; mon_en = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; mem_ack = 1'b0;
        reset = 1'b1;
        #3;
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);
        check("rst_wrap_addr", bus_w.imem_addr, 32'hFFFF_FFF8);

        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        next_pc = 32'h0; stale = 1'b0; skid_full = 1'b0; exp_valid = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        check("rel_imem_req", {31'b0, bus.imem_req}, 32'h1);
        check("wrap_addr0", bus_w.imem_addr, 32'hFFFF_FFF8);

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clock);
            if (cyc == 0) check("wrap_addr1", bus_w.imem_addr, 32'hFFFF_FFFC);
            if (cyc == 1) begin
                check("wrap_addr2", bus_w.imem_addr, 32'h0);
                check("wrap_pc", w_pc, 32'hFFFF_FFFC);
                check("wrap_pc4", w_pc4, 32'h0);
            end
            tgt = 32'h0;
            rdr = 1'b0;
            if (cyc < 10) begin
                stl = 1'b0; ack = 1'b1;
            end else if (cyc < 13) begin
                stl = 1'b1; ack = 1'b1;
            end else if (cyc == 13) begin
                stl = 1'b0; ack = 1'b0;
            end else if (cyc == 14) begin
                stl = 1'b1; ack = 1'b1;
            end else if (cyc == 15) begin
                stl = 1'b1; ack = 1'b0; rdr = 1'b1; tgt = 32'h0000_0200;
            end else begin
                stl = ($urandom_range(3) == 0);
                ack = $urandom_range(1) == 1;
                rdr = ($urandom_range(19) == 0);
                tgt = $urandom_range(32'hFFFF);
            end
            drive_cycle(stl, rdr, ack, tgt);
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive_cycle(1'b0, 1'b0, i < 2, 32'h0);
        end
        @(negedge clock);
        check("queue_drained", exp_q.size(), 32'h0);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0);

        @(negedge clock);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_if_valid", {31'b0, if_valid}, 32'h0);
        check("async_if_pc", if_pc, 32'h0);
        check("async_if_instr", if_instr, 32'h0);
        check("async_imem_addr", bus.imem_addr, 32'h0);
        check("async_imem_req", {31'b0, bus.imem_req}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
